// File: rtl/ccff_loader_pkg.sv
// Shared types and helpers for the ccff chain loader: FSM state encoding and
// the per-word bit-count rule used when the chain length is not a word multiple.
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SHIFT,
    DONE
  } state_t;

  // Bits to shift for the next word: a full word, or whatever is left of the chain.
  function automatic int calc_nbits(input int word_w, input int remaining);
    return (remaining < word_w) ? remaining : word_w;
  endfunction

endpackage

// File: rtl/ccff_serdes.sv
// Word serializer toward ccff_head and deserializer from ccff_tail; runs one
// burst of nbits enabled chain edges per load pulse.
module ccff_serdes #(
  parameter int WORD_W = 8,
  localparam int NB_W = $clog2(WORD_W + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [WORD_W-1:0] data,
  input  logic [NB_W-1:0]   nbits,
  input  logic              tail,
  output logic              head,
  output logic              shift_en,
  output logic              last,
  output logic [WORD_W-1:0] capture
);

  logic [WORD_W-1:0] wsr_reg;
  logic [WORD_W-2:0] rsr_reg;
  logic [NB_W-1:0]   cnt_reg;
  logic              shift_en_reg;
  logic [WORD_W-1:0] aligned;

  // Left-justify the used bits so the head bit is always the MSB; the low
  // bits shifted in are zero, which returns head to 0 after the last bit.
  assign aligned  = data << (NB_W'(WORD_W) - nbits);
  assign capture  = {rsr_reg, tail};
  assign last     = shift_en_reg && (cnt_reg == NB_W'(1));
  assign head     = wsr_reg[WORD_W-1];
  assign shift_en = shift_en_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wsr_reg      <= '0;
      rsr_reg      <= '0;
      cnt_reg      <= '0;
      shift_en_reg <= 1'b0;
    end else if (load) begin
      wsr_reg      <= aligned;
      rsr_reg      <= '0;
      cnt_reg      <= nbits;
      shift_en_reg <= 1'b1;
    end else if (shift_en_reg) begin
      wsr_reg <= wsr_reg << 1;
      rsr_reg <= capture[WORD_W-2:0];
      cnt_reg <= cnt_reg - NB_W'(1);
      if (cnt_reg == NB_W'(1)) begin
        shift_en_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ccff_chain_loader.sv
// ccff chain bitstream loader: host words in over valid/ready, serialized into
// the chain, with the displaced chain contents returned as readback words.
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int CHAIN_LEN = 64,
  localparam int CNT_W = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              start,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid,
  input  logic              rb_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bit_count
);

  localparam int NB_W = $clog2(WORD_W + 1);

  state_t            state_reg;
  logic              busy_reg;
  logic              done_reg;
  logic [CNT_W-1:0]  bit_count_reg;
  logic [WORD_W-1:0] rb_data_reg;
  logic              rb_valid_reg;
  logic              accept;
  logic              last;
  logic [NB_W-1:0]   nbits;
  logic [WORD_W-1:0] capture;

  // A pending readback blocks the next word so the one-deep buffer never overflows.
  assign wr_ready = (state_reg == FETCH) && !rb_valid_reg;
  assign accept   = wr_valid && wr_ready;
  assign nbits    = NB_W'(calc_nbits(WORD_W, CHAIN_LEN - int'(bit_count_reg)));

  ccff_serdes #(
    .WORD_W(WORD_W)
  ) u_serdes (
    .clk      (prog_clk),
    .rst_n    (prog_reset_n),
    .load     (accept),
    .data     (wr_data),
    .nbits    (nbits),
    .tail     (ccff_tail),
    .head     (ccff_head),
    .shift_en (ccff_shift_en),
    .last     (last),
    .capture  (capture)
  );

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      state_reg     <= IDLE;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      bit_count_reg <= '0;
      rb_data_reg   <= '0;
      rb_valid_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (rb_valid_reg && rb_ready) begin
        rb_valid_reg <= 1'b0;
      end
      case (state_reg)
        IDLE: begin
          if (start) begin
            bit_count_reg <= '0;
            busy_reg      <= 1'b1;
            state_reg     <= FETCH;
          end
        end
        FETCH: begin
          if (accept) begin
            state_reg <= SHIFT;
          end
        end
        SHIFT: begin
          bit_count_reg <= bit_count_reg + CNT_W'(1);
          if (last) begin
            rb_data_reg  <= capture;
            rb_valid_reg <= 1'b1;
            if (bit_count_reg == CNT_W'(CHAIN_LEN - 1)) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= FETCH;
            end
          end
        end
        DONE: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy      = busy_reg;
  assign done      = done_reg;
  assign bit_count = bit_count_reg;
  assign rb_data   = rb_data_reg;
  assign rb_valid  = rb_valid_reg;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Scoreboard bench for ccff_chain_loader with a behavioural 20-bit chain and a
// bit-queue reference model of what the chain and readback must contain.
module tb_ccff_chain_loader;

  localparam int WW = 8;
  localparam int CL = 20;
  localparam int CW = $clog2(CL + 1);
  localparam int TMO = 300;

  logic          prog_clk = 1'b0;
  logic          prog_reset_n = 1'b0;
  logic          start = 1'b0;
  logic [WW-1:0] wr_data = '0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [WW-1:0] rb_data;
  logic          rb_valid;
  logic          rb_ready = 1'b1;
  logic          ccff_head;
  logic          ccff_shift_en;
  logic          ccff_tail;
  logic          busy;
  logic          done;
  logic [CW-1:0] bit_count;

  logic [CL-1:0] chain;
  logic [CL-1:0] preload_val = '0;
  bit            preload_req = 1'b0;

  int vecs = 0;
  int errs = 0;
  int cyc = 0;
  int done_cyc = 0;
  int done_cnt = 0;
  int run = 0;
  bit rb_rand = 1'b0;
  bit rb_val = 1'b1;
  logic [WW-1:0] rb_exp[$];
  int            shift_exp[$];
  logic [WW-1:0] words[3];

  ccff_chain_loader #(.WORD_W(WW), .CHAIN_LEN(CL)) dut (
    .prog_clk      (prog_clk),
    .prog_reset_n  (prog_reset_n),
    .start         (start),
    .wr_data       (wr_data),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .rb_data       (rb_data),
    .rb_valid      (rb_valid),
    .rb_ready      (rb_ready),
    .ccff_head     (ccff_head),
    .ccff_shift_en (ccff_shift_en),
    .ccff_tail     (ccff_tail),
    .busy          (busy),
    .done          (done),
    .bit_count     (bit_count)
  );

  initial forever #5 prog_clk = ~prog_clk;

  // Fabric chain: shifts toward the MSB, the MSB is what leaves at the tail.
  always @(posedge prog_clk) begin
    if (preload_req) chain <= preload_val;
    else if (ccff_shift_en) chain <= {chain[CL-2:0], ccff_head};
  end
  assign ccff_tail = chain[CL-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_tmo(input string name);
    vecs++;
    errs++;
    $display("FAIL %s: no event within %0d cycles, required one", name, TMO);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge prog_clk);
      #1;
    end
  endtask

  task automatic preload(input logic [CL-1:0] v);
    preload_val = v;
    preload_req = 1'b1;
    tick(1);
    preload_req = 1'b0;
  endtask

  initial forever begin
    @(posedge prog_clk);
    #1;
    rb_ready = rb_rand ? ($urandom_range(99) < 50) : rb_val;
  end

  // Monitor: pops expectations whenever the DUT hands over a readback word or
  // finishes a burst of shift-enabled cycles.
  initial forever begin
    @(negedge prog_clk);
    cyc++;
    if (!prog_reset_n) begin
      run = 0;
    end else begin
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (rb_valid && rb_ready) begin
        if (rb_exp.size() == 0) begin
          vecs++; errs++;
          $display("FAIL rb_extra: got word 0x%0h, required none", rb_data);
        end else begin
          chk("rb_data", rb_data, rb_exp.pop_front());
        end
      end
      if (ccff_shift_en) begin
        run++;
      end else if (run > 0) begin
        if (shift_exp.size() == 0) begin
          vecs++; errs++;
          $display("FAIL shift_extra: got burst of %0d, required none", run);
        end else begin
          chk("shift_burst_len", run, shift_exp.pop_front());
        end
        run = 0;
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_wr_ready"}, wr_ready, 0);
    chk({tag, "_rb_data"}, rb_data, 0);
    chk({tag, "_rb_valid"}, rb_valid, 0);
    chk({tag, "_head"}, ccff_head, 0);
    chk({tag, "_shift_en"}, ccff_shift_en, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_bit_count"}, bit_count, 0);
  endtask

  task automatic do_load(input bit gaps, input bit bp, input bit bad_start,
                         input bit rst_mid, input bit tput);
    logic [CL-1:0] snap, exp_chain, snap2;
    bit            oldq[$];
    bit            newq[$];
    logic [WW-1:0] v;
    int            rem, n, nw, s, t;

    // Reference: the chain is a FIFO of bits; new bits push old ones out in order.
    snap = chain;
    for (int i = CL - 1; i >= 0; i--) oldq.push_back(snap[i]);
    rem = CL;
    nw = 0;
    while (rem > 0) begin
      n = (rem < WW) ? rem : WW;
      for (int j = n - 1; j >= 0; j--) newq.push_back(words[nw][j]);
      v = '0;
      for (int j = 0; j < n; j++) v = {v[WW-2:0], oldq.pop_front()};
      rb_exp.push_back(v);
      shift_exp.push_back(n);
      rem -= n;
      nw++;
    end
    exp_chain = '0;
    for (int i = 0; i < CL; i++) exp_chain = {exp_chain[CL-2:0], newq[i]};

    if (bp) rb_val = 1'b0;
    done_cnt = 0;
    tick(1);
    start = 1'b1;
    s = cyc + 1;
    tick(1);
    start = 1'b0;
    wr_data = words[0];
    wr_valid = tput;
    chk("busy_after_start", busy, 1);
    chk("bit_count_cleared", bit_count, 0);

    for (int k = 0; k < nw; k++) begin
      if (gaps) begin
        wr_valid = 1'b0;
        tick($urandom_range(3));
      end
      wr_data = words[k];
      wr_valid = 1'b1;
      t = 0;
      while (!wr_ready && t < TMO) begin
        tick(1);
        t++;
      end
      if (t >= TMO) begin
        fail_tmo("wr_accept");
        wr_valid = 1'b0;
        return;
      end
      tick(1);
      if (!tput) wr_valid = 1'b0;
      chk("shift_en_after_accept", ccff_shift_en, 1);
      if (k == 0 && bad_start) begin
        start = 1'b1;
        tick(1);
        start = 1'b0;
      end
      if (k == 0 && bp) begin
        t = 0;
        while (!rb_valid && t < TMO) begin
          tick(1);
          t++;
        end
        if (t >= TMO) fail_tmo("bp_rb_valid");
        snap2 = chain;
        wr_data = words[1];
        wr_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
          tick(1);
          chk("bp_wr_ready", wr_ready, 0);
          chk("bp_shift_en", ccff_shift_en, 0);
          chk("bp_chain", chain, snap2);
        end
        rb_val = 1'b1;
      end
      if (k == 1 && rst_mid) begin
        tick(3);
        #2;
        prog_reset_n = 1'b0;
        #1;
        chk_reset_outputs("mid_reset");
        rb_exp.delete();
        shift_exp.delete();
        tick(1);
        prog_reset_n = 1'b1;
        wr_valid = 1'b0;
        $display("load aborted by reset during word 1, bit_count=%0d", bit_count);
        return;
      end
    end
    wr_valid = 1'b0;

    t = 0;
    while (!done && t < TMO) begin
      tick(1);
      t++;
    end
    if (t >= TMO) fail_tmo("done");
    if (bad_start) begin
      start = 1'b1;
      tick(1);
      start = 1'b0;
      chk("start_on_done_busy", busy, 0);
      tick(1);
      chk("start_on_done_wr_ready", wr_ready, 0);
      chk("start_on_done_busy2", busy, 0);
    end
    tick(2);
    chk("done_pulses", done_cnt, 1);
    if (tput) chk("load_cycles", done_cyc - s + 1, CL + 2 * nw + 1);
    t = 0;
    while (rb_exp.size() != 0 && t < TMO) begin
      tick(1);
      t++;
    end
    if (t >= TMO) fail_tmo("rb_drain");
    chk("chain_contents", chain, exp_chain);
    chk("bit_count_final", bit_count, CL);
    chk("busy_idle", busy, 0);
    chk("bursts_all_seen", shift_exp.size(), 0);
    $display("load words=%02h %02h %02h prior=%05h chain=%05h bit_count=%0d",
             words[0], words[1], words[2], snap, chain, bit_count);
  endtask

  initial begin
    preload(20'hABCDE);
    tick(2);
    chk_reset_outputs("reset");
    prog_reset_n = 1'b1;
    tick(1);

    // Words offered in IDLE must be refused.
    wr_data = 8'h55;
    wr_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick(1);
      chk("idle_wr_ready", wr_ready, 0);
      chk("idle_shift_en", ccff_shift_en, 0);
    end
    wr_valid = 1'b0;

    words = '{8'hA5, 8'h3C, 8'h09};
    do_load(0, 0, 0, 0, 0);
    chk("full_load_const", chain, 20'hA53C9);

    preload(20'hABCDE);
    words = '{8'h5A, 8'hC3, 8'hF6};
    do_load(0, 1, 0, 0, 0);

    preload(20'h13579);
    words = '{8'h81, 8'h7E, 8'hB2};
    do_load(0, 0, 1, 0, 0);

    preload(20'hABCDE);
    do_load(0, 0, 0, 1, 0);
    preload(20'hABCDE);
    words = '{8'hA5, 8'h3C, 8'h09};
    do_load(0, 0, 0, 0, 0);
    chk("after_reset_const", chain, 20'hA53C9);

    preload(20'hFEDCB);
    words = '{8'h12, 8'h34, 8'h56};
    do_load(0, 0, 0, 0, 1);

    rb_rand = 1'b1;
    for (int r = 0; r < 6; r++) begin
      preload(CL'($urandom));
      for (int k = 0; k < 3; k++) words[k] = WW'($urandom);
      do_load(1, 0, 0, 0, 0);
    end
    rb_rand = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
